// File: rtl/dm_arbiter.sv
// dm_arbiter -- data-memory arbiter between the CPU M-stage port and an
// external loader/debug port, in front of a single data memory with an
// ack-based handshake.
//
// Transaction flow: IDLE (grant + latch) -> BUSY (mem_req held until mem_ack
// or timeout) -> RESP (one-cycle done pulse to the owner) -> IDLE.
//
// BUSY lasts at most TIMEOUT cycles. The ack-less cycle counter holds
// TIMEOUT-1 in the last allowed BUSY cycle. If mem_ack is absent in that
// cycle, the transaction aborts with err=1. If mem_ack is present in that
// cycle, the ack wins.
//
// Build option: define DM_ARB_RR_EN for round-robin arbitration on ties.
// When it is undefined, the CPU has fixed priority and no pointer exists.
module dm_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        cpu_done,
    output logic        ext_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter value in the last BUSY cycle that is allowed to wait for mem_ack.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic        owner_ext_r;
    logic        any_req_s;
    logic        grant_ext_s;
    logic        timeout_s;
    logic        win_we_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;

    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        mem_req_r;
    logic        cpu_done_r;
    logic        ext_done_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        mem_req_nxt_s;
    logic        cpu_done_nxt_s;
    logic        ext_done_nxt_s;
    logic [31:0] rdata_nxt_s;
    logic        err_nxt_s;

    assign any_req_s = cpu_req | ext_req;
    assign timeout_s = (cnt_r == TO_LAST);

`ifdef DM_ARB_RR_EN
    // Last-served pointer: 1 = EXT was served last, so the CPU wins the first tie.
    logic last_ext_r;

    // Record the winner of every grant taken in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_ext_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            last_ext_r <= grant_ext_s;
        end
    end

    // Round-robin winner select: on a tie, the port not served last wins.
    always_comb begin
        grant_ext_s = 1'b0;
        if (cpu_req && ext_req) begin
            grant_ext_s = ~last_ext_r;
        end else begin
            grant_ext_s = ext_req;
        end
    end
`else
    // Fixed-priority winner select: the CPU always beats the external port.
    always_comb begin
        grant_ext_s = 1'b0;
        if (cpu_req) begin
            grant_ext_s = 1'b0;
        end else begin
            grant_ext_s = ext_req;
        end
    end
`endif

    // Multiplex the winning port's request fields.
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = 32'd0;
        win_wdata_s = 32'd0;
        if (grant_ext_s) begin
            win_we_s    = ext_we;
            win_addr_s  = ext_addr;
            win_wdata_s = ext_wdata;
        end else begin
            win_we_s    = cpu_we;
            win_addr_s  = cpu_addr;
            win_wdata_s = cpu_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    // mem_ack is only looked at in BUSY.
    always_comb begin
        mem_req_nxt_s  = 1'b0;
        cpu_done_nxt_s = 1'b0;
        ext_done_nxt_s = 1'b0;
        rdata_nxt_s    = 32'd0;
        err_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    mem_req_nxt_s = 1'b1;
                end else begin
                    mem_req_nxt_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    cpu_done_nxt_s = ~owner_ext_r;
                    ext_done_nxt_s = owner_ext_r;
                    rdata_nxt_s    = mem_we_r ? 32'd0 : mem_rdata;
                    err_nxt_s      = 1'b0;
                end else if (timeout_s) begin
                    cpu_done_nxt_s = ~owner_ext_r;
                    ext_done_nxt_s = owner_ext_r;
                    rdata_nxt_s    = 32'd0;
                    err_nxt_s      = 1'b1;
                end else begin
                    mem_req_nxt_s  = 1'b1;
                end
            end
            ST_RESP: mem_req_nxt_s = 1'b0;
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

    // Transaction context: latch the grant in IDLE, count ack-less BUSY cycles.
    // Owner, fields and counter base stay frozen until the transaction retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_ext_r <= 1'b0;
            cnt_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_ext_r <= grant_ext_s;
                        cnt_r       <= 8'd0;
                        mem_we_r    <= win_we_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
                    end
                end
                ST_BUSY: begin
                    if (!mem_ack && !timeout_s) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake outputs; reset clears them immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_r  <= 1'b0;
            cpu_done_r <= 1'b0;
            ext_done_r <= 1'b0;
            rdata_r    <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            mem_req_r  <= mem_req_nxt_s;
            cpu_done_r <= cpu_done_nxt_s;
            ext_done_r <= ext_done_nxt_s;
            rdata_r    <= rdata_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_done  = cpu_done_r;
    assign ext_done  = ext_done_r;
    assign rdata     = rdata_r;
    assign err       = err_r;
    assign cpu_stall = cpu_req & ~cpu_done_r;

endmodule
